cdb_arbiter: RTL and testbench

- Schedules the shared common data bus between completing functional units and the ROB, map table and reservation stations.
- Each cycle it selects up to CDB_WIDTH of NUM_FU requesting units using a rotating-priority scan.
- It returns same-cycle grants to the functional units and drives a registered CDB broadcast on the next cycle.
- The broadcast is what the ROB consumes as cdb_pr_ready / cdb_pr_tag.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_rr_picker.sv | 39 +++
 rtl/cdb_arbiter.sv | 83 ++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB sizing and functional-unit numbering, also used by the ROB and reservation stations.
package cdb_arbiter_pkg;

  localparam int NUM_FU    = 8;
  localparam int CDB_WIDTH = 6;
  localparam int PR_WIDTH  = 7;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_ALU2 = 2;
  localparam int FU_ALU3 = 3;
  localparam int FU_MULT = 4;
  localparam int FU_DIV  = 5;
  localparam int FU_LDST = 6;
  localparam int FU_BR   = 7;

endpackage

// File: rtl/cdb_rr_picker.sv
// Rotating-priority picker: grants the first CDB_WIDTH requesters scanning from ptr,
// and reports each grantee's slot number plus the last index granted.
module cdb_rr_picker #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 6,
  parameter int IDX_W     = 3,
  parameter int SLOT_W    = 3
) (
  input  logic [NUM_FU-1:0]             req,
  input  logic [IDX_W-1:0]              ptr,
  output logic [NUM_FU-1:0]             gnt,
  output logic [NUM_FU-1:0][SLOT_W-1:0] slot_idx,
  output logic [IDX_W-1:0]              last_idx,
  output logic                          any_gnt
);

  always_comb begin
    int cnt;
    int idx;
    gnt      = '0;
    slot_idx = '0;
    last_idx = ptr;
    cnt      = 0;
    idx      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      // slot number is the grant order within the scan, so slots pack from 0
      if (req[idx] && cnt < CDB_WIDTH) begin
        gnt[idx]      = 1'b1;
        slot_idx[idx] = SLOT_W'(cnt);
        last_idx      = IDX_W'(idx);
        cnt           = cnt + 1;
      end
    end
    any_gnt = |gnt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: same-cycle grants to FUs, registered broadcast of the
// granted tags one cycle later, packed into contiguous slots.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int CDB_WIDTH = cdb_arbiter_pkg::CDB_WIDTH,
  parameter int PR_WIDTH  = cdb_arbiter_pkg::PR_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_req,
  input  logic [NUM_FU*PR_WIDTH-1:0]    fu_tag,
  output logic [NUM_FU-1:0]             fu_gnt,
  output logic [CDB_WIDTH-1:0]          cdb_pr_ready,
  output logic [CDB_WIDTH*PR_WIDTH-1:0] cdb_pr_tag,
  output logic                          cdb_busy
);

  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SLOT_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

  logic [IDX_W-1:0]                     rr_ptr;
  logic [NUM_FU-1:0]                    req_live;
  logic [NUM_FU-1:0]                    gnt;
  logic [NUM_FU-1:0][SLOT_W-1:0]        slot_idx;
  logic [IDX_W-1:0]                     last_idx;
  logic                                 any_gnt;
  logic [CDB_WIDTH-1:0]                 nxt_rdy;
  logic [CDB_WIDTH-1:0][PR_WIDTH-1:0]   nxt_tag;
  logic [NUM_FU-1:0][PR_WIDTH-1:0]      tag_arr;
  logic [CDB_WIDTH-1:0]                 rdy_q;
  logic [CDB_WIDTH-1:0][PR_WIDTH-1:0]   tag_q;

  // masking requests during reset/flush kills grants, slot loads and pointer motion at once
  assign req_live = (reset || flush) ? '0 : fu_req;
  assign tag_arr  = fu_tag;

  cdb_rr_picker #(
    .NUM_FU   (NUM_FU),
    .CDB_WIDTH(CDB_WIDTH),
    .IDX_W    (IDX_W),
    .SLOT_W   (SLOT_W)
  ) u_picker (
    .req     (req_live),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .slot_idx(slot_idx),
    .last_idx(last_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    nxt_rdy = '0;
    nxt_tag = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        nxt_rdy[slot_idx[i]] = 1'b1;
        nxt_tag[slot_idx[i]] = tag_arr[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      rdy_q  <= '0;
      tag_q  <= '0;
    end else begin
      rdy_q <= nxt_rdy;
      tag_q <= nxt_tag;
      if (any_gnt)
        rr_ptr <= (last_idx == IDX_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  assign fu_gnt       = gnt;
  assign cdb_pr_ready = rdy_q;
  assign cdb_pr_tag   = tag_q;
  assign cdb_busy     = ($countones(fu_req) > CDB_WIDTH);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter at default sizing (8 FUs, 6 slots, 7-bit tags).
module tb_cdb_arbiter;

  logic             clock;
  logic             reset;
  logic             flush;
  logic [7:0]       fu_req;
  logic [7:0][6:0]  tags;
  logic [7:0]       fu_gnt;
  logic [5:0]       cdb_pr_ready;
  logic [41:0]      cdb_pr_tag;
  logic             cdb_busy;

  int vectors;
  int miscompares;

  cdb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .fu_req      (fu_req),
    .fu_tag      (tags),
    .fu_gnt      (fu_gnt),
    .cdb_pr_ready(cdb_pr_ready),
    .cdb_pr_tag  (cdb_pr_tag),
    .cdb_busy    (cdb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic [7:0] exp);
    vectors++;
    if (fu_gnt !== exp) begin
      miscompares++;
      $display("FAIL %s fu_gnt got %h want %h", name, fu_gnt, exp);
    end
  endtask

  task automatic chk_bcast(input string name, input logic [5:0] exp_rdy,
                           input logic [41:0] exp_tag, input logic [2:0] exp_ptr);
    vectors++;
    if (cdb_pr_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL %s cdb_pr_ready got %b want %b", name, cdb_pr_ready, exp_rdy);
    end
    vectors++;
    if (cdb_pr_tag !== exp_tag) begin
      miscompares++;
      $display("FAIL %s cdb_pr_tag got %h want %h", name, cdb_pr_tag, exp_tag);
    end
    vectors++;
    if (dut.rr_ptr !== exp_ptr) begin
      miscompares++;
      $display("FAIL %s rr_ptr got %0d want %0d", name, dut.rr_ptr, exp_ptr);
    end
  endtask

  task automatic set_tags_40();
    for (int i = 0; i < 8; i++) tags[i] = 7'(40 + i);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    flush  = 1'b1;
    fu_req = 8'hFF;
    set_tags_40();
    #1;
    chk_gnt("reset_gnt", 8'h00);
    tick();
    chk_bcast("reset_state", 6'b0, 42'h0, 3'd0);
    flush  = 1'b0;
    fu_req = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_full();
    fu_req = 8'hFF;
    set_tags_40();
    #1;
    chk_gnt("full_gnt", 8'h3F);
    vectors++;
    if (cdb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL full_busy got %b want 1", cdb_busy);
    end
    tick();
    chk_bcast("full_bcast", 6'b111111,
              {7'd45, 7'd44, 7'd43, 7'd42, 7'd41, 7'd40}, 3'd6);
  endtask

  task automatic test_tail();
    fu_req = 8'hC0;
    #1;
    chk_gnt("tail_gnt", 8'hC0);
    vectors++;
    if (cdb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tail_busy got %b want 0", cdb_busy);
    end
    tick();
    chk_bcast("tail_bcast", 6'b000011, {28'h0, 7'd47, 7'd46}, 3'd0);
  endtask

  task automatic test_idle();
    fu_req = 8'h00;
    #1;
    chk_gnt("idle_gnt", 8'h00);
    tick();
    chk_bcast("idle_bcast", 6'b0, 42'h0, 3'd0);
  endtask

  task automatic test_wrap();
    // FU5 alone moves the pointer to 6
    fu_req = 8'h20;
    tick();
    chk_bcast("wrap_setup", 6'b000001, {35'h0, 7'd45}, 3'd6);
    fu_req  = 8'b11000011;
    tags[0] = 7'd10;
    tags[1] = 7'd11;
    tags[6] = 7'd16;
    tags[7] = 7'd17;
    #1;
    chk_gnt("wrap_gnt", 8'hC3);
    tick();
    chk_bcast("wrap_bcast", 6'b001111,
              {14'h0, 7'd11, 7'd10, 7'd17, 7'd16}, 3'd2);
  endtask

  task automatic test_flush();
    // FU7 alone puts the pointer back to 0
    fu_req = 8'h80;
    tick();
    chk_bcast("flush_setup", 6'b000001, {35'h0, 7'd17}, 3'd0);
    fu_req  = 8'h05;
    tags[0] = 7'd20;
    tags[2] = 7'd22;
    flush   = 1'b1;
    #1;
    chk_gnt("flush_gnt", 8'h00);
    tick();
    chk_bcast("flush_bcast", 6'b0, 42'h0, 3'd0);
    flush = 1'b0;
    #1;
    chk_gnt("post_flush_gnt", 8'h05);
    tick();
    chk_bcast("post_flush_bcast", 6'b000011, {28'h0, 7'd22, 7'd20}, 3'd3);
  endtask

  task automatic test_reset_mid();
    fu_req = 8'hFF;
    set_tags_40();
    #1;
    chk_gnt("mid_gnt", 8'hF9);
    tick();
    chk_bcast("mid_bcast", 6'b111111,
              {7'd40, 7'd47, 7'd46, 7'd45, 7'd44, 7'd43}, 3'd1);
    reset = 1'b1;
    #1;
    chk_gnt("mid_reset_gnt", 8'h00);
    tick();
    chk_bcast("mid_reset_bcast", 6'b0, 42'h0, 3'd0);
    reset = 1'b0;
  endtask

  task automatic test_soak();
    logic [7:0] exp_g [4];
    logic [7:0] prev;
    exp_g[0] = 8'h3F;
    exp_g[1] = 8'hCF;
    exp_g[2] = 8'hF3;
    exp_g[3] = 8'hFC;
    prev     = 8'h00;
    fu_req   = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk_gnt("soak_gnt", exp_g[c % 4]);
      if (c > 0) begin
        vectors++;
        if ((fu_gnt | prev) !== 8'hFF) begin
          miscompares++;
          $display("FAIL soak_fair cycle %0d union got %h want ff", c, fu_gnt | prev);
        end
      end
      prev = fu_gnt;
      tick();
      vectors++;
      if ($countones(cdb_pr_ready) != 6) begin
        miscompares++;
        $display("FAIL soak_ready cycle %0d got %b want 6 ones", c, cdb_pr_ready);
      end
    end
    fu_req = 8'h00;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    fu_req      = 8'h00;
    tags        = '0;
    tick();
    test_reset();
    test_full();
    test_tail();
    test_idle();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
